// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared FSM encoding, defaults and ID-width helper for the IRQ arbiter
package irq_pkg;

  localparam int IRQ_DEFAULT_NUM  = 4;
  localparam int IRQ_DEFAULT_SYNC = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2,
    ST_RETURN  = 2'd3
  } irq_state_t;

  // Width of an IRQ index; a single line still needs one bit.
  function automatic int irq_id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - single-bit multi-flop synchroniser with async active-low reset
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_request_arbiter.sv
// rtl/interrupt_request_arbiter.sv - fixed-priority IRQ arbiter feeding the interrupt controller
// IRQ_EDGE_DETECT_EN selects edge-triggered pending bits; undefined gives level-sensitive lines.
module interrupt_request_arbiter
  import irq_pkg::*;
#(
  parameter int  NUM_IRQ     = IRQ_DEFAULT_NUM,
  parameter int  SYNC_STAGES = IRQ_DEFAULT_SYNC,
  localparam int ID_W        = irq_id_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               sel_ISR,
  input  logic               ret_ISR,
  output logic               interrupt_signal,
  output logic [ID_W-1:0]    irq_id,
  output logic               irq_active,
  output logic [NUM_IRQ-1:0] irq_pending
);

  irq_state_t         state;
  irq_state_t         state_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic               int_nxt;
  logic               active_nxt;
  logic [NUM_IRQ-1:0] irq_sync_q;
  logic [NUM_IRQ-1:0] eligible;
  logic [ID_W-1:0]    winner_id;
  logic               sel_q;
  logic               ret_q;
  logic               sel_rise;
  logic               ret_rise;
  logic               ret_fall;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .nrst (nrst),
      .d    (irq_in[g]),
      .q    (irq_sync_q[g])
    );
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sel_q <= 1'b0;
      ret_q <= 1'b0;
    end else begin
      sel_q <= sel_ISR;
      ret_q <= ret_ISR;
    end
  end

  assign sel_rise = sel_ISR & ~sel_q;
  assign ret_rise = ret_ISR & ~ret_q;
  assign ret_fall = ~ret_ISR & ret_q;

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] sync_prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] ack_clr;
  logic               ack;

  assign ack  = (state == ST_REQ) && sel_rise;
  assign rise = irq_sync_q & ~sync_prev;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_clr[i] = ack && (irq_id == ID_W'(i));
    end
  end

  // A rising edge arriving in the same cycle as the ack survives the clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_prev   <= '0;
      irq_pending <= '0;
    end else begin
      sync_prev   <= irq_sync_q;
      irq_pending <= (irq_pending & ~ack_clr) | rise;
    end
  end
`else
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      irq_pending <= '0;
    end else begin
      irq_pending <= irq_sync_q;
    end
  end
`endif

  assign eligible = irq_pending & ~irq_mask;

  // Scan from the top so the lowest eligible index is the last one written.
  always_comb begin
    winner_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner_id = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state            <= ST_IDLE;
      irq_id           <= '0;
      interrupt_signal <= 1'b1;
      irq_active       <= 1'b0;
    end else begin
      state            <= state_nxt;
      irq_id           <= id_nxt;
      interrupt_signal <= int_nxt;
      irq_active       <= active_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    id_nxt     = irq_id;
    int_nxt    = interrupt_signal;
    active_nxt = irq_active;
    case (state)
      ST_IDLE: begin
        if (|eligible) begin
          id_nxt    = winner_id;
          int_nxt   = 1'b0;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sel_rise) begin
          int_nxt    = 1'b1;
          active_nxt = 1'b1;
          state_nxt  = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (ret_rise) begin
          state_nxt = ST_RETURN;
        end
      end
      ST_RETURN: begin
        if (ret_fall) begin
          active_nxt = 1'b0;
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_request_arbiter.sv
// tb/tb_interrupt_request_arbiter.sv - self-checking bench for interrupt_request_arbiter
module tb_interrupt_request_arbiter;

  localparam int N = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         nrst;
  logic [N-1:0] irq_in;
  logic [N-1:0] irq_mask;
  logic         sel_ISR;
  logic         ret_ISR;
  logic         interrupt_signal;
  logic [1:0]   irq_id;
  logic         irq_active;
  logic [N-1:0] irq_pending;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] m_hist[$];
  logic [N-1:0] m_pend;
  int           m_mode;
  logic         m_int;
  logic         m_act;
  logic [1:0]   m_id;
  logic         m_sel_prev;
  logic         m_ret_prev;

  always #5 clk = ~clk;

  interrupt_request_arbiter #(
    .NUM_IRQ(N),
    .SYNC_STAGES(S)
  ) dut (
    .clk              (clk),
    .nrst             (nrst),
    .irq_in           (irq_in),
    .irq_mask         (irq_mask),
    .sel_ISR          (sel_ISR),
    .ret_ISR          (ret_ISR),
    .interrupt_signal (interrupt_signal),
    .irq_id           (irq_id),
    .irq_active       (irq_active),
    .irq_pending      (irq_pending)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < S + 2; i++) m_hist.push_back('0);
    m_pend     = '0;
    m_mode     = 0;
    m_int      = 1'b1;
    m_act      = 1'b0;
    m_id       = '0;
    m_sel_prev = 1'b0;
    m_ret_prev = 1'b0;
  endfunction

  // Line history view: the pending logic sees the input from S edges ago.
  function automatic void model_step();
    logic [N-1:0] elig;
    logic [N-1:0] clr;
    logic [N-1:0] rise;
    clr  = '0;
    elig = m_pend & ~irq_mask;
    case (m_mode)
      0: if (elig != 0) begin
        for (int i = 0; i < N; i++) begin
          if (elig[i]) begin
            m_id = 2'(i);
            break;
          end
        end
        m_int  = 1'b0;
        m_mode = 1;
      end
      1: if (sel_ISR && !m_sel_prev) begin
        clr[m_id] = 1'b1;
        m_int  = 1'b1;
        m_act  = 1'b1;
        m_mode = 2;
      end
      2: if (ret_ISR && !m_ret_prev) m_mode = 3;
      default: if (!ret_ISR && m_ret_prev) begin
        m_act  = 1'b0;
        m_mode = 0;
      end
    endcase
    m_hist.push_front(irq_in);
    void'(m_hist.pop_back());
    rise = m_hist[S] & ~m_hist[S+1];
`ifdef IRQ_EDGE_DETECT_EN
    m_pend = (m_pend & ~clr) | rise;
`else
    m_pend = m_hist[S];
`endif
    m_sel_prev = sel_ISR;
    m_ret_prev = ret_ISR;
  endfunction

  task automatic reset_all();
    irq_in   = '0;
    irq_mask = '0;
    sel_ISR  = 1'b0;
    ret_ISR  = 1'b0;
    nrst     = 1'b0;
    tick(2);
    nrst = 1'b1;
    tick(1);
    model_reset();
  endtask

  task automatic test_reset();
    reset_all();
    checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b want=0", irq_active); end
    irq_in = 4'b0100;
    tick(4);
    checks++; if (interrupt_signal !== 1'b0) begin errors++; $display("FAIL reset_pre_req got=%b want=0", interrupt_signal); end
    #2 nrst = 1'b0;
    #1;
    checks++; if (interrupt_signal !== 1'b1) begin errors++; $display("FAIL reset_int got=%b want=1", interrupt_signal); end
    checks++; if (irq_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d want=0", irq_id); end
    checks++; if (irq_pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got=%b want=0000", irq_pending); end
    irq_in = '0;
    tick(2);
    nrst = 1'b1;
    tick(4);
    checks++; if (interrupt_signal !== 1'b1) begin errors++; $display("FAIL reset_lost got=%b want=1", interrupt_signal); end
  endtask

  task automatic test_single();
    reset_all();
    irq_in = 4'b0100;
    tick(3);
    checks++; if (interrupt_signal !== 1'b1) begin errors++; $display("FAIL single_early got=%b want=1", interrupt_signal); end
    checks++; if (irq_pending !== 4'b0100) begin errors++; $display("FAIL single_pend got=%b want=0100", irq_pending); end
    tick(1);
    checks++; if (interrupt_signal !== 1'b0) begin errors++; $display("FAIL single_post got=%b want=0", interrupt_signal); end
    checks++; if (irq_id !== 2'd2) begin errors++; $display("FAIL single_id got=%0d want=2", irq_id); end
    sel_ISR = 1'b1;
    tick(1);
    checks++; if (interrupt_signal !== 1'b1) begin errors++; $display("FAIL single_ack_int got=%b want=1", interrupt_signal); end
    checks++; if (irq_active !== 1'b1) begin errors++; $display("FAIL single_ack_act got=%b want=1", irq_active); end
`ifdef IRQ_EDGE_DETECT_EN
    checks++; if (irq_pending !== 4'b0000) begin errors++; $display("FAIL single_ack_pend got=%b want=0000", irq_pending); end
`else
    checks++; if (irq_pending !== 4'b0100) begin errors++; $display("FAIL single_ack_pend got=%b want=0100", irq_pending); end
`endif
    sel_ISR = 1'b0;
    irq_in  = '0;
    tick(4);
    ret_ISR = 1'b1;
    tick(1);
    checks++; if (irq_active !== 1'b1) begin errors++; $display("FAIL single_ret_hi got=%b want=1", irq_active); end
    ret_ISR = 1'b0;
    tick(1);
    checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL single_ret_lo got=%b want=0", irq_active); end
    tick(3);
    checks++; if (interrupt_signal !== 1'b1) begin errors++; $display("FAIL single_idle got=%b want=1", interrupt_signal); end
  endtask

  task automatic test_priority();
    reset_all();
    irq_in = 4'b1001;
    tick(4);
    checks++; if (interrupt_signal !== 1'b0) begin errors++; $display("FAIL prio_post got=%b want=0", interrupt_signal); end
    checks++; if (irq_id !== 2'd0) begin errors++; $display("FAIL prio_first got=%0d want=0", irq_id); end
    sel_ISR = 1'b1;
    tick(1);
    sel_ISR = 1'b0;
    irq_in  = 4'b1000;
    tick(4);
    ret_ISR = 1'b1;
    tick(1);
    ret_ISR = 1'b0;
    tick(1);
    checks++; if (interrupt_signal !== 1'b1) begin errors++; $display("FAIL prio_gap got=%b want=1", interrupt_signal); end
    tick(1);
    checks++; if (interrupt_signal !== 1'b0) begin errors++; $display("FAIL prio_second got=%b want=0", interrupt_signal); end
    checks++; if (irq_id !== 2'd3) begin errors++; $display("FAIL prio_second_id got=%0d want=3", irq_id); end
  endtask

  task automatic test_masking();
    reset_all();
    irq_mask = 4'b0001;
    irq_in   = 4'b0001;
    tick(5);
    checks++; if (irq_pending[0] !== 1'b1) begin errors++; $display("FAIL mask_pend got=%b want=1", irq_pending[0]); end
    checks++; if (interrupt_signal !== 1'b1) begin errors++; $display("FAIL mask_hold got=%b want=1", interrupt_signal); end
    irq_mask = 4'b0000;
    tick(1);
    checks++; if (interrupt_signal !== 1'b0) begin errors++; $display("FAIL mask_release got=%b want=0", interrupt_signal); end
    checks++; if (irq_id !== 2'd0) begin errors++; $display("FAIL mask_id got=%0d want=0", irq_id); end
  endtask

  task automatic test_retrigger();
    reset_all();
    irq_in = 4'b0010;
    tick(4);
    checks++; if (irq_id !== 2'd1) begin errors++; $display("FAIL retrig_id got=%0d want=1", irq_id); end
    sel_ISR = 1'b1;
    tick(1);
    sel_ISR = 1'b0;
    irq_in  = '0;
    tick(4);
    checks++; if (irq_pending[1] !== 1'b0) begin errors++; $display("FAIL retrig_clear got=%b want=0", irq_pending[1]); end
    irq_in = 4'b0010;
    tick(4);
    checks++; if (irq_pending[1] !== 1'b1) begin errors++; $display("FAIL retrig_pend got=%b want=1", irq_pending[1]); end
    checks++; if (interrupt_signal !== 1'b1) begin errors++; $display("FAIL retrig_svc got=%b want=1", interrupt_signal); end
    ret_ISR = 1'b1;
    tick(1);
    checks++; if (interrupt_signal !== 1'b1) begin errors++; $display("FAIL retrig_ret got=%b want=1", interrupt_signal); end
    ret_ISR = 1'b0;
    tick(1);
    checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL retrig_act got=%b want=0", irq_active); end
    tick(1);
    checks++; if (interrupt_signal !== 1'b0) begin errors++; $display("FAIL retrig_repost got=%b want=0", interrupt_signal); end
    checks++; if (irq_id !== 2'd1) begin errors++; $display("FAIL retrig_repost_id got=%0d want=1", irq_id); end
  endtask

  task automatic test_level();
    reset_all();
    irq_in = 4'b0010;
    tick(4);
    sel_ISR = 1'b1;
    tick(1);
    sel_ISR = 1'b0;
    tick(2);
`ifdef IRQ_EDGE_DETECT_EN
    checks++; if (irq_pending !== 4'b0000) begin errors++; $display("FAIL level_pend got=%b want=0000", irq_pending); end
`else
    checks++; if (irq_pending !== 4'b0010) begin errors++; $display("FAIL level_pend got=%b want=0010", irq_pending); end
`endif
    ret_ISR = 1'b1;
    tick(1);
    ret_ISR = 1'b0;
    tick(1);
    checks++; if (irq_active !== 1'b0) begin errors++; $display("FAIL level_act got=%b want=0", irq_active); end
    tick(1);
`ifdef IRQ_EDGE_DETECT_EN
    checks++; if (interrupt_signal !== 1'b1) begin errors++; $display("FAIL level_norepost got=%b want=1", interrupt_signal); end
`else
    checks++; if (interrupt_signal !== 1'b0) begin errors++; $display("FAIL level_repost got=%b want=0", interrupt_signal); end
    checks++; if (irq_id !== 2'd1) begin errors++; $display("FAIL level_repost_id got=%0d want=1", irq_id); end
`endif
  endtask

  task automatic test_random();
    reset_all();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 11) == 0) irq_in[b] = ~irq_in[b];
      end
      if ($urandom_range(0, 63) == 0) irq_mask = N'($urandom) & N'($urandom);
      sel_ISR = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      if (m_mode == 2)      ret_ISR = ($urandom_range(0, 2) == 0);
      else if (m_mode == 3) ret_ISR = ($urandom_range(0, 2) != 0);
      else                  ret_ISR = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      model_step();
      #1;
      checks++; if (interrupt_signal !== m_int) begin errors++; $display("FAIL rand_int cyc=%0d got=%b want=%b", c, interrupt_signal, m_int); end
      checks++; if (irq_id !== m_id) begin errors++; $display("FAIL rand_id cyc=%0d got=%0d want=%0d", c, irq_id, m_id); end
      checks++; if (irq_active !== m_act) begin errors++; $display("FAIL rand_act cyc=%0d got=%b want=%b", c, irq_active, m_act); end
      checks++; if (irq_pending !== m_pend) begin errors++; $display("FAIL rand_pend cyc=%0d got=%b want=%b", c, irq_pending, m_pend); end
    end
  endtask

  initial begin
    irq_in   = '0;
    irq_mask = '0;
    sel_ISR  = 1'b0;
    ret_ISR  = 1'b0;
    nrst     = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_retrigger();
    test_level();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
